// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search controller.
//   state_t           : controller states (IDLE, TRIAL, DONE)
//   SAR_DEFAULT_WIDTH : default guess/result width, also the number of search steps
package sar_pkg;

    localparam int unsigned SAR_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRIAL = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : sar_pkg

// File: rtl/sar_search.sv
// Successive-approximation search controller. Drives trial values to a
// magnitude comparator (guess -> A, hidden target -> B) and converges on the
// target MSB first using only bit-set/bit-clear steps.
//
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   start      : begin a search; sampled only in IDLE
//   cmp_gt     : comparator flag, guess > target (settled before each edge)
//   cmp_eq     : comparator flag, guess == target (used only with early exit)
//   guess      : registered trial value to comparator A
//   busy       : registered, high while in TRIAL
//   done       : registered one-cycle pulse, result valid from this cycle
//   result     : registered recovered target, held until the next accepted start
//
// Build option:
//   SAR_EARLY_EXIT_EN : when defined, cmp_eq in TRIAL ends the search at once
//                       with result = guess (cmp_eq has priority over cmp_gt).
module sar_search
    import sar_pkg::*;
#(
    parameter int unsigned WIDTH = SAR_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state, state_d;
    logic [IDX_W-1:0]   idx, idx_d;
    logic [WIDTH-1:0]   guess_d, result_d;
    logic               busy_d, done_d;
    logic [WIDTH-1:0]   nxt_c;

`ifndef SAR_EARLY_EXIT_EN
    // Equality flag only matters for the early-exit build.
    logic unused_cmp_eq;
    assign unused_cmp_eq = cmp_eq;
`endif

    // Step value: drop the bit under trial when the guess overshoots.
    always_comb begin
        nxt_c = guess;
        if (cmp_gt) begin
            nxt_c[idx] = 1'b0;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state;
        idx_d    = idx;
        guess_d  = guess;
        result_d = result;

        unique case (state)
            IDLE: begin
                guess_d = '0;
                if (start) begin
                    guess_d = WIDTH'(1) << (WIDTH - 1);
                    idx_d   = IDX_W'(WIDTH - 1);
                    state_d = TRIAL;
                end
            end
            TRIAL: begin
`ifdef SAR_EARLY_EXIT_EN
                if (cmp_eq) begin
                    result_d = guess;
                    state_d  = DONE;
                end else
`endif
                if (idx == '0) begin
                    result_d = nxt_c;
                    state_d  = DONE;
                end else begin
                    // Keep the decided bit, then try the next lower bit.
                    guess_d = nxt_c | (WIDTH'(1) << (idx - IDX_W'(1)));
                    idx_d   = idx - IDX_W'(1);
                end
            end
            DONE: begin
                guess_d = '0;
                state_d = IDLE;
            end
            default: begin
                guess_d = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == TRIAL);
        done_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= IDX_W'(WIDTH - 1);
            guess  <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_d;
            idx    <= idx_d;
            guess  <= guess_d;
            result <= result_d;
            busy   <= busy_d;
            done   <= done_d;
        end
    end

endmodule : sar_search
